// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one byte in flight over a valid/ready handshake, LSB first.
// The line is driven straight from the shift register LSB, so the pin has no combinational path.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] LAST_CYCLE   = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] PENULT_CYCLE = CW'(SYMBOL_EDGE_TIME - 2);
    localparam logic [3:0]    STOP_BIT     = 4'd9;

    // Handshake: a byte moves on a rising edge where data_in_valid && data_in_ready;
    // data_in is only sampled then, and valid without ready is simply ignored.
    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [9:0]      shift_reg;
    logic [CW-1:0]   cycle_cnt;
    logic [3:0]      bit_cnt;
    logic            accept;

    assign accept     = data_in_valid && data_in_ready;
    assign serial_out = shift_reg[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            shift_reg     <= '1;
            cycle_cnt     <= '0;
            bit_cnt       <= '0;
            data_in_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= SEND;
                        shift_reg     <= {1'b1, data_in, 1'b0};
                        cycle_cnt     <= '0;
                        bit_cnt       <= '0;
                        data_in_ready <= 1'b0;
                    end
                end
                SEND: begin
                    if (cycle_cnt == LAST_CYCLE) begin
                        cycle_cnt <= '0;
                        if (bit_cnt == STOP_BIT) begin
                            bit_cnt <= '0;
                            // A byte accepted on the last stop-bit cycle starts immediately.
                            if (accept) begin
                                shift_reg     <= {1'b1, data_in, 1'b0};
                                data_in_ready <= 1'b0;
                            end else begin
                                state         <= IDLE;
                                shift_reg     <= '1;
                                data_in_ready <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 4'd1;
                            shift_reg <= {1'b1, shift_reg[9:1]};
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                        // Open the handshake one cycle early so ready covers the final stop-bit cycle.
                        if (bit_cnt == STOP_BIT && cycle_cnt == PENULT_CYCLE)
                            data_in_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    shift_reg     <= '1;
                    data_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame-position model checked every cycle,
// plus literal expectations for specific frames and a production-rate instance.
module tb_uart_transmitter;

    localparam int N  = 10;
    localparam int PN = 434;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;

    logic [7:0] p_data = 8'h00;
    logic       p_valid = 1'b0;
    logic       p_ready;
    logic       p_serial;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .serial_out(serial_out)
    );

    uart_transmitter #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(115_200)) dut_p (
        .clk(clk), .rst(rst), .data_in(p_data), .data_in_valid(p_valid),
        .data_in_ready(p_ready), .serial_out(p_serial)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: position within the current frame decides the line and ready.
    logic       m_active = 1'b0;
    int         m_pos = 0;
    logic [9:0] m_frame = '1;
    logic       m_serial = 1'b1;
    logic       m_ready = 1'b1;
    logic       ready_now;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else begin
            ready_now = !m_active || (m_pos == 10*N - 1);
            if (data_in_valid && ready_now) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_frame  = {1'b1, data_in, 1'b0};
            end else if (m_active) begin
                m_pos++;
                if (m_pos == 10*N) m_active = 1'b0;
            end
        end
        m_serial = m_active ? m_frame[m_pos / N] : 1'b1;
        m_ready  = !m_active || (m_pos == 10*N - 1);
    end

    always @(negedge clk) begin
        check("cmp_line", serial_out, m_serial);
        check("cmp_ready", data_in_ready, m_ready);
    end

    int   line_rec[0:199];
    int   rdy_rec[0:199];
    logic p_line[0:4399];
    logic p_rdy[0:4399];
    int   exp_a5[0:9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    task automatic start_byte(input logic [7:0] b);
        @(negedge clk);
        data_in       = b;
        data_in_valid = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        int cnt;
        int err;
        int start;
        int last_low;
        logic [7:0] byte_v;

        // Reset held with valid asserted
        data_in       = 8'h5A;
        data_in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rst_line", serial_out, 1);
            check("rst_ready", data_in_ready, 1);
        end
        data_in_valid = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", serial_out, 1);

        // Single byte 0xA5
        start_byte(8'hA5);
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            line_rec[j] = serial_out;
            rdy_rec[j]  = data_in_ready;
            if (j == 0) data_in_valid = 1'b0;
        end
        err = 0;
        cnt = 0;
        for (int b = 0; b < 10; b++) begin
            check($sformatf("a5_bit%0d", b), line_rec[b*N + N/2], exp_a5[b]);
            for (int c = 0; c < N; c++)
                if (line_rec[b*N + c] != exp_a5[b]) err++;
        end
        check("a5_hold", err, 0);
        for (int j = 0; j < 99; j++)
            if (rdy_rec[j] == 0) cnt++;
        check("a5_ready_low", cnt, 99);
        check("a5_ready_last", rdy_rec[99], 1);
        @(negedge clk);
        check("a5_idle_line", serial_out, 1);

        // Back-to-back 0x00 then 0xFF
        start_byte(8'h00);
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            line_rec[j] = serial_out;
            rdy_rec[j]  = data_in_ready;
            if (j == 0) data_in = 8'hFF;
            if (j == 100) data_in_valid = 1'b0;
        end
        cnt = 0;
        for (int j = 0; j < 100; j++)
            if (line_rec[j] == 0) cnt++;
        check("b2b_zeros_first", cnt, 90);
        check("b2b_stop", line_rec[99], 1);
        check("b2b_second_start", line_rec[100], 0);
        check("b2b_ready_99", rdy_rec[99], 1);
        check("b2b_ready_100", rdy_rec[100], 0);
        cnt = 0;
        for (int j = 100; j < 200; j++)
            if (line_rec[j] == 0) cnt++;
        check("b2b_zeros_second", cnt, 10);
        check("b2b_ready_199", rdy_rec[199], 1);
        @(negedge clk);
        check("b2b_idle_line", serial_out, 1);

        // Hold-off: valid pulse with 0x3C while 0x55 is in flight
        start_byte(8'h55);
        for (int j = 0; j < 130; j++) begin
            @(negedge clk);
            line_rec[j] = serial_out;
            rdy_rec[j]  = data_in_ready;
            if (j == 0) data_in_valid = 1'b0;
            if (j == 35) begin
                data_in       = 8'h3C;
                data_in_valid = 1'b1;
            end
            if (j == 36) data_in_valid = 1'b0;
        end
        for (int b = 0; b < 8; b++) byte_v[b] = line_rec[(b+1)*N + N/2][0];
        check("holdoff_byte", byte_v, 8'h55);
        check("holdoff_ready_35", rdy_rec[35], 0);
        cnt = 0;
        for (int j = 100; j < 130; j++)
            if (line_rec[j] == 1) cnt++;
        check("holdoff_no_3c", cnt, 30);

        // Reset during data bit 3 of 0x81
        start_byte(8'h81);
        for (int j = 0; j < 45; j++) begin
            @(negedge clk);
            if (j == 0) data_in_valid = 1'b0;
        end
        check("rst5_pre_line", serial_out, 0);
        #2 rst = 1'b0;
        #1;
        check("rst5_async_line", serial_out, 1);
        check("rst5_async_ready", data_in_ready, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        cnt = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (serial_out == 1'b1 && data_in_ready == 1'b1) cnt++;
        end
        check("rst5_idle_after", cnt, 30);
        start_byte(8'hC3);
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (105) @(negedge clk);

        // Production parameters, N = 434
        @(negedge clk);
        p_data  = 8'h41;
        p_valid = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 4400; j++) begin
            @(negedge clk);
            p_line[j] = p_serial;
            p_rdy[j]  = p_ready;
            if (j == 0) p_valid = 1'b0;
        end
        start = -1;
        last_low = -1;
        for (int j = 4399; j >= 0; j--) begin
            if (p_line[j] == 1'b0) begin
                start = j;
                if (last_low < 0) last_low = j;
            end
        end
        check("p_start", start, 0);
        for (int b = 0; b < 8; b++) byte_v[b] = p_line[start + PN*(b+1) + PN/2];
        check("p_byte", byte_v, 8'h41);
        check("p_stop", p_line[start + 9*PN + PN/2], 1);
        check("p_last_low", last_low, 3905);
        cnt = 0;
        for (int j = 0; j < 4400; j++)
            if (p_rdy[j] == 1'b0) cnt++;
        check("p_ready_low", cnt, 4339);
        check("p_ready_4338", p_rdy[4338], 0);
        check("p_ready_4339", p_rdy[4339], 1);
        cnt = 0;
        for (int j = 4340; j < 4400; j++)
            if (p_line[j] == 1'b1) cnt++;
        check("p_idle_after", cnt, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
